operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Operand-fetch stage directly upstream of the execute ALU. Holds the 32-entry general register file.
- Reads two source registers, or one register plus a sign-extended immediate.
- Registers a, b, shift and funct into an output stage with a valid/ready handshake; the ALU consumes these outputs.
- Accepts one write-back port from the downstream stage.

Parameters:
- tamOp, 32, data width of registers and operands.
- NREG, 32, number of registers; address width is fixed at 5 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction fields valid
- in_ready  output  1  stage can accept this cycle
- ra  input  5  source register A address
- rb  input  5  source register B address
- imm  input  16  immediate
- use_imm  input  1  b takes sext(imm) instead of rb
- shift_in  input  5  shift amount
- funct_in  input  6  ALU function code
- wb_en  input  1  write-back enable
- wb_addr  input  5  write-back address
- wb_data  input  tamOp  write-back data
- out_valid  output  1  a/b/shift/funct valid for the ALU
- out_ready  input  1  ALU side accepts
- a  output  tamOp  operand A
- b  output  tamOp  operand B
- shift  output  5  registered shift_in
- funct  output  6  registered funct_in

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NREG registers cleared to 0
  - out_valid=0; a, b, shift and funct all 0
  - in_ready follows the combinational rule below, so it is 1 during and after reset
- Register 0 is hardwired to 0. Reads return 0, and wb_en with wb_addr=0 is ignored.
- Write: on a rising clk edge with wb_en=1 and wb_addr!=0, rf[wb_addr] <= wb_data.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational, single-entry pipe).
  - Accept occurs when in_valid & in_ready.
  - On accept, at the clock edge:
    - a <= rd(ra)
    - b <= use_imm ? {{(tamOp-16){imm[15]}}, imm} : rd(rb)
    - shift <= shift_in, funct <= funct_in
    - out_valid <= 1
  - If there is no accept and out_ready=1, out_valid <= 0. Data outputs hold their last value.
  - Latency: 1 cycle from accept to out_valid.
  - Throughput: 1 per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - a, b, shift and funct are held stable.
  - A write-back to a held source register does NOT update the held operands (snapshot semantics).
- Simultaneous accept and out_ready: the new transaction replaces the old one in the same edge, and out_valid stays 1.
- rd(x) is defined as:
  - 0 if x=0
  - otherwise rf[x], subject to the bypass rule under Optional Feature
- ra=rb is legal; both operands get the same value.
- If use_imm=1, rb is ignored and no bypass applies to b.
- Reset asserted mid-transaction discards the pending output (out_valid=0) and clears the file. No partial state survives.
- No X propagation: the outputs come only from registers.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined (same-cycle write-through): if wb_en=1, wb_addr!=0 and wb_addr equals the read address, rd() returns wb_data instead of rf[].
- Undefined: rd() returns the pre-write rf[] contents. The upstream control must then insert one bubble on a read-after-write hazard.

Test Plan:
- Reset state:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle.
  - Response: out_valid=0 and a=b=0 immediately.
  - Then, after release, accept ra=5, rb=7 → a=0 and b=0.
- Write then read:
  - Stimulus: wb r5=0x0000_1234 and r7=0xFFFF_FFFE, then accept ra=5, rb=7, funct_in=6'b000101, shift_in=3.
  - Response: next cycle out_valid=1, a=0x1234, b=0xFFFFFFFE, funct=000101, shift=3.
- Immediate and r0:
  - Stimulus: wb r0=0xDEAD_BEEF, then accept ra=0, use_imm=1, imm=16'h8001.
  - Response: a=0, b=0xFFFF8001.
  - Stimulus: accept with imm=16'h7FFF.
  - Response: b=0x00007FFF.
- Backpressure:
  - Stimulus: accept ra=5 (r5=0x10), then hold out_ready=0 for 3 cycles while writing r5=0x20.
  - Response: a stays 0x10 and in_ready=0 throughout.
  - Stimulus: out_ready=1.
  - Response: in_ready=1 the same cycle; a new accept of ra=5 gives a=0x20.
- Bypass:
  - Stimulus: r3=0x1 in the file; in the same cycle as the accept of ra=3, wb r3=0x99.
  - Response: with OPERAND_FETCH_BYPASS_EN defined, a=0x99; undefined, a=0x1.
- Back-to-back:
  - Stimulus: in_valid=1 and out_ready=1 for 4 cycles with ra=1..4 (rN=N*0x11).
  - Response: out_valid=1 continuously, with a=0x11, 0x22, 0x33, 0x44 on consecutive cycles.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32-entry register file, two read ports (or reg + sign-extended imm),
// one write-back port, and a single-entry valid/ready output register feeding the ALU.
// Optional same-cycle write-through bypass: define OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
    parameter int tamOp = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ra,
    input  logic [4:0]       rb,
    input  logic [15:0]      imm,
    input  logic             use_imm,
    input  logic [4:0]       shift_in,
    input  logic [5:0]       funct_in,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [tamOp-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [tamOp-1:0] a,
    output logic [tamOp-1:0] b,
    output logic [4:0]       shift,
    output logic [5:0]       funct
);

    logic [tamOp-1:0] rf_q [NREG];
    logic [NREG-1:0]  we;

    logic             out_valid_q;
    logic [tamOp-1:0] a_q, a_d;
    logic [tamOp-1:0] b_q, b_d;
    logic [4:0]       shift_q;
    logic [5:0]       funct_q;
    logic             accept;

    // Entry 0 never has its write enable raised, so it stays at its reset value of 0.
    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_rf
            assign we[i] = (i != 0) && wb_en && (wb_addr == 5'(i));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rf_q[i] <= '0;
                else if (we[i])
                    rf_q[i] <= wb_data;
            end
        end
    endgenerate

    function automatic logic [tamOp-1:0] rd(input logic [4:0] x);
        logic [tamOp-1:0] v;
        v = '0;
        if (x != 5'd0 && 32'(x) < NREG) begin
            v = rf_q[x];
`ifdef OPERAND_FETCH_BYPASS_EN
            if (wb_en && wb_addr == x)
                v = wb_data;
`endif
        end
        return v;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        a_d = rd(ra);
        b_d = use_imm ? {{(tamOp-16){imm[15]}}, imm} : rd(rb);
    end

    // Operands are a snapshot taken at accept; later write-backs never touch a held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            shift_q     <= '0;
            funct_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            a_q         <= a_d;
            b_q         <= b_d;
            shift_q     <= shift_in;
            funct_q     <= funct_in;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign shift     = shift_q;
    assign funct     = funct_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, read/write, immediate, r0, backpressure, bypass, streaming.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  ra, rb;
    logic [15:0] imm;
    logic        use_imm;
    logic [4:0]  shift_in;
    logic [5:0]  funct_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] a, b;
    logic [4:0]  shift;
    logic [5:0]  funct;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_fetch #(.tamOp(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ra(ra), .rb(rb), .imm(imm), .use_imm(use_imm),
        .shift_in(shift_in), .funct_in(funct_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .shift(shift), .funct(funct)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wb(input logic [4:0] ad, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = ad; wb_data = d;
        nxt();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r_a, input logic [4:0] r_b, input logic ui,
                         input logic [15:0] im);
        in_valid = 1'b1; ra = r_a; rb = r_b; use_imm = ui; imm = im;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ra = '0; rb = '0; imm = '0; use_imm = 1'b0;
        shift_in = '0; funct_in = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        out_ready = 1'b1;
        nxt();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_shift_funct", {21'd0, shift, funct}, 32'd0);
        rst_n = 1'b1;
        nxt();

        // write then read
        wb(5'd5, 32'h0000_1234);
        wb(5'd7, 32'hFFFF_FFFE);
        issue(5'd5, 5'd7, 1'b0, 16'h0); funct_in = 6'b000101; shift_in = 5'd3;
        nxt();
        in_valid = 1'b0;
        chk("wr_rd_valid", 32'(out_valid), 32'd1);
        chk("wr_rd_a", a, 32'h0000_1234);
        chk("wr_rd_b", b, 32'hFFFF_FFFE);
        chk("wr_rd_funct", 32'(funct), 32'd5);
        chk("wr_rd_shift", 32'(shift), 32'd3);
        nxt();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold_a", a, 32'h0000_1234);

        // reset mid-transaction
        issue(5'd5, 5'd7, 1'b0, 16'h0);
        nxt();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_a", a, 32'd0);
        chk("async_rst_b", b, 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        nxt();
        rst_n = 1'b1; out_ready = 1'b1;
        issue(5'd5, 5'd7, 1'b0, 16'h0);
        nxt();
        in_valid = 1'b0;
        chk("post_rst_a", a, 32'd0);
        chk("post_rst_b", b, 32'd0);

        // immediate and r0
        wb(5'd7, 32'h0000_AAAA);
        wb(5'd0, 32'hDEAD_BEEF);
        issue(5'd0, 5'd7, 1'b1, 16'h8001);
        nxt();
        chk("r0_a", a, 32'd0);
        chk("imm_neg_b", b, 32'hFFFF_8001);
        issue(5'd0, 5'd7, 1'b1, 16'h7FFF);
        nxt();
        chk("imm_pos_b", b, 32'h0000_7FFF);
        issue(5'd0, 5'd0, 1'b0, 16'h0);
        nxt();
        in_valid = 1'b0;
        chk("r0_b", b, 32'd0);
        nxt();

        // backpressure with snapshot semantics
        wb(5'd5, 32'h10);
        issue(5'd5, 5'd5, 1'b0, 16'h0); out_ready = 1'b0;
        nxt();
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h20;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_a", a, 32'h10);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            nxt();
        end
        wb_en = 1'b0;
        chk("stall_end_a", a, 32'h10);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        nxt();
        in_valid = 1'b0;
        chk("release_a", a, 32'h20);
        chk("release_b", b, 32'h20);
        nxt();

        // same-cycle write/read
        wb(5'd3, 32'h1);
        issue(5'd3, 5'd3, 1'b0, 16'h0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
        nxt();
        wb_en = 1'b0; in_valid = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        chk("bypass_a", a, 32'h99);
`else
        chk("nobypass_a", a, 32'h1);
`endif
        issue(5'd3, 5'd3, 1'b0, 16'h0);
        nxt();
        in_valid = 1'b0;
        chk("after_wb_a", a, 32'h99);
        nxt();

        // back-to-back streaming
        for (int n = 1; n <= 4; n++) wb(5'(n), 32'(n * 32'h11));
        for (int n = 1; n <= 4; n++) begin
            issue(5'(n), 5'(n), 1'b0, 16'h0);
            nxt();
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_a", a, 32'(n * 32'h11));
        end
        in_valid = 1'b0;
        nxt();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
